// File: rtl/fluid_level_warn.sv
// Per-channel debounced low-level warning with a recovery hysteresis threshold.
// Define WARN_LATCH_EN to hold each warning after recovery until it is acknowledged.
module fluid_level_warn #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic        [CHANNELS*WIDTH-1:0]               level,
  input  logic signed [WIDTH-1:0]                        thr_low,
  input  logic signed [WIDTH-1:0]                        thr_high,
  input  logic        [CHANNELS-1:0]                     ack,
  output logic        [CHANNELS-1:0]                     warn,
  output logic                                           warn_any,
  output logic        [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] first_ch
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

`ifdef WARN_LATCH_EN
  typedef enum logic [2:0] {StOk, StPend, StWarn, StClr, StLatched} state_e;
  localparam state_e StRecovered = StLatched;
`else
  typedef enum logic [2:0] {StOk, StPend, StWarn, StClr} state_e;
  localparam state_e StRecovered = StOk;
  logic ack_unused;
  assign ack_unused = ^ack;
`endif

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CntW-1:0]     cnt_q   [CHANNELS];
  logic [CntW-1:0]     cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] low, high, warn_d, warn_q;
  logic                warn_any_q;
  logic [IdxW-1:0]     first_ch_d, first_ch_q;
  logic signed [WIDTH-1:0] thr_rec;

  // Recovery never sits below the low threshold, even if thr_high is misprogrammed.
  assign thr_rec = (thr_high >= thr_low) ? thr_high : thr_low;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      low[i]   = $signed(level[i*WIDTH +: WIDTH]) < thr_low;
      high[i]  = $signed(level[i*WIDTH +: WIDTH]) >= thr_rec;
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      unique case (state_q[i])
        StOk: begin
          if (low[i]) begin
            if (DEBOUNCE == 1) begin
              state_d[i] = StWarn;
            end else begin
              state_d[i] = StPend;
              cnt_d[i]   = CntW'(1);
            end
          end
        end
        StPend: begin
          if (!low[i]) begin
            state_d[i] = StOk;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StWarn;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StWarn: begin
          if (high[i]) begin
            if (DEBOUNCE == 1) begin
              state_d[i] = StRecovered;
            end else begin
              state_d[i] = StClr;
              cnt_d[i]   = CntW'(1);
            end
          end
        end
        StClr: begin
          if (!high[i]) begin
            state_d[i] = StWarn;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StRecovered;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
`ifdef WARN_LATCH_EN
        StLatched: begin
          if (low[i]) begin
            state_d[i] = StWarn;
          end else if (ack[i]) begin
            state_d[i] = StOk;
          end
        end
`endif
        default: state_d[i] = StOk;
      endcase
      warn_d[i] = (state_d[i] != StOk) && (state_d[i] != StPend);
    end
  end

  // Lowest-numbered warning channel wins; scan downward so it is written last.
  always_comb begin
    first_ch_d = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (warn_d[i]) first_ch_d = IdxW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= StOk;
        cnt_q[i]   <= '0;
      end
      warn_q     <= '0;
      warn_any_q <= 1'b0;
      first_ch_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      warn_q     <= warn_d;
      warn_any_q <= |warn_d;
      first_ch_q <= first_ch_d;
    end
  end

  assign warn     = warn_q;
  assign warn_any = warn_any_q;
  assign first_ch = first_ch_q;

endmodule

// File: tb/tb_fluid_level_warn.sv
// Directed bench for fluid_level_warn: expected warn vectors are queued per step
// and checked after the clock edge that registers that step's inputs.
module tb_fluid_level_warn;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEBOUNCE = 4;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [CHANNELS*WIDTH-1:0]  level;
  logic signed [WIDTH-1:0]    thr_low, thr_high;
  logic [CHANNELS-1:0]        ack;
  logic [CHANNELS-1:0]        warn;
  logic                       warn_any;
  logic [1:0]                 first_ch;

  int checks = 0;
  int errors = 0;
  int lv [CHANNELS];
  logic [CHANNELS-1:0] exp_q [$];

  fluid_level_warn #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .level    (level),
    .thr_low  (thr_low),
    .thr_high (thr_high),
    .ack      (ack),
    .warn     (warn),
    .warn_any (warn_any),
    .first_ch (first_ch)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] lowest(input logic [CHANNELS-1:0] w);
    logic [1:0] r = 2'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (w[i]) r = 2'(i);
    return r;
  endfunction

  task automatic set_lv(input int l0, input int l1, input int l2, input int l3);
    lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
  endtask

  // Drive current levels, expect `ew` after the next rising edge.
  task automatic cyc(input string tag, input logic [CHANNELS-1:0] ew);
    logic [CHANNELS-1:0] e;
    for (int i = 0; i < CHANNELS; i++) level[i*WIDTH +: WIDTH] = lv[i];
    exp_q.push_back(ew);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (warn === e) else begin
      errors++;
      $error("FAIL %s warn got %b exp %b", tag, warn, e);
    end
    checks++;
    assert (warn_any === (|e)) else begin
      errors++;
      $error("FAIL %s warn_any got %b exp %b", tag, warn_any, |e);
    end
    checks++;
    assert (first_ch === lowest(e)) else begin
      errors++;
      $error("FAIL %s first_ch got %0d exp %0d", tag, first_ch, lowest(e));
    end
  endtask

  initial begin
    reset = 1'b1; ack = '0; thr_low = 10; thr_high = 20; level = '0;
    set_lv(0, 0, 0, 0);
    #2;
    // Reset held with all channels low
    for (int k = 0; k < 15; k++) cyc("reset_hold", 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc("release_pend", 4'b0000);
    cyc("release_warn", 4'b1111);

    // Re-reset, then park all channels in the hysteresis band (neither low nor high)
    reset = 1'b1; set_lv(15, 15, 15, 15);
    cyc("reset2", 4'b0000);
    reset = 1'b0;
    cyc("idle_band", 4'b0000);

    // Channel 1: level equal to thr_low is non-low and breaks the run
    set_lv(15, 10, 15, 15); cyc("ch1_eq_thr", 4'b0000);
    set_lv(15, 9, 15, 15);
    for (int k = 0; k < 3; k++) cyc("ch1_run1", 4'b0000);
    set_lv(15, 10, 15, 15); cyc("ch1_break", 4'b0000);
    set_lv(15, 9, 15, 15);
    for (int k = 0; k < 3; k++) cyc("ch1_run2", 4'b0000);
    cyc("ch1_warn", 4'b0010);

    // Channel 2 into warning; ack on a non-latched channel is ignored
    set_lv(15, 9, 9, 15); ack = 4'b0010;
    for (int k = 0; k < 3; k++) cyc("ch2_pend", 4'b0010);
    ack = '0;
    cyc("ch2_warn", 4'b0110);

    // Recovery interrupted by a mid-band sample, ack during CLR ignored
    set_lv(15, 9, 30, 15); ack = 4'b0100;
    cyc("ch2_clr_ack", 4'b0110);
    ack = '0;
    for (int k = 0; k < 2; k++) cyc("ch2_clr", 4'b0110);
    set_lv(15, 9, 15, 15); cyc("ch2_band", 4'b0110);
    set_lv(15, 9, 30, 15);
    for (int k = 0; k < 3; k++) cyc("ch2_clr2", 4'b0110);
`ifdef WARN_LATCH_EN
    cyc("ch2_latched", 4'b0110);
    cyc("ch2_hold", 4'b0110);
    ack = 4'b0100; cyc("ch2_ack", 4'b0010);
    ack = '0;
`else
    cyc("ch2_recover", 4'b0010);
    cyc("ch2_stay_ok", 4'b0010);
`endif

    // Channel 3 warns, then reset lands while channels 1 and 3 are mid-recovery
    set_lv(15, 9, 15, 9);
    for (int k = 0; k < 3; k++) cyc("ch3_pend", 4'b0010);
    cyc("ch3_warn", 4'b1010);
    set_lv(15, 30, 15, 30);
    for (int k = 0; k < 2; k++) cyc("ch13_clr", 4'b1010);
    reset = 1'b1; cyc("reset_mid_clr", 4'b0000);
    reset = 1'b0; set_lv(15, 15, 15, 15);
    cyc("after_reset", 4'b0000);

    // thr_high below thr_low: recovery uses thr_low, so level 10 counts as high
    thr_high = 5;
    set_lv(9, 15, 15, 15);
    for (int k = 0; k < 3; k++) cyc("ch0_pend", 4'b0000);
    cyc("ch0_warn", 4'b0001);
    set_lv(10, 15, 15, 15);
    for (int k = 0; k < 3; k++) cyc("ch0_clr", 4'b0001);
    cyc("ch0_recover", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
